// File: rtl/display_pkg.sv
// Shared definitions for the seven-segment display scan path.
//   view_state_t : view FSM encoding (HM = clock view, SEC = seconds view)
//   SCAN_W       : width of the digit-scan index
//   NUM_DIGITS   : number of multiplexed digits
package display_pkg;

    typedef enum logic {
        HM  = 1'b0,
        SEC = 1'b1
    } view_state_t;

    localparam int SCAN_W     = 2;
    localparam int NUM_DIGITS = 4;

endpackage

// File: rtl/btn_onepulse.sv
// Button conditioner: 2-flop synchronizer, stability-counter debouncer and
// rising-edge one-shot.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   btn   : raw asynchronous button level
//   press : one-cycle pulse per accepted press (releases give no pulse)
module btn_onepulse #(
    parameter int DEB_CYC = 1000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int DEB_W = $clog2(DEB_CYC + 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             level_q_r;
    logic [DEB_W-1:0] stab_cnt_r;

    // Synchronize, debounce against the accepted level and form the press pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r    <= 1'b0;
            sync2_r    <= 1'b0;
            level_r    <= 1'b0;
            level_q_r  <= 1'b0;
            stab_cnt_r <= '0;
            press      <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
            // The counter only runs while the input disagrees with the accepted
            // level; any return to agreement (a bounce) restarts it.
            if (sync2_r != level_r) begin
                if (stab_cnt_r == DEB_W'(DEB_CYC - 1)) begin
                    level_r    <= sync2_r;
                    stab_cnt_r <= '0;
                end else begin
                    stab_cnt_r <= stab_cnt_r + DEB_W'(1);
                end
            end else begin
                stab_cnt_r <= '0;
            end
            level_q_r <= level_r;
            press     <= level_r & ~level_q_r;
        end
    end

endmodule

// File: rtl/display_scan_scheduler.sv
// Digit-scan sequencer for a 4-digit seven-segment multiplexer with
// anti-ghosting blanking, plus the content / 12-24 h view settings that are
// only allowed to change on frame boundaries.
//   clk, rst_n   : clock, asynchronous active-low reset
//   btn_content  : raw content-view button
//   btn_system   : raw 12/24 h button
//   scan_idx     : current digit slot (0 = rightmost)
//   content      : 0 = HH:MM, 1 = seconds
//   time_system  : 0 = 12 h, 1 = 24 h
//   blank        : all anodes off while high
//   frame_tick   : one-cycle pulse after scan_idx wraps 3 -> 0
module display_scan_scheduler
    import display_pkg::*;
#(
    parameter int SCAN_DIV      = 100000,
    parameter int BLANK_CYC     = 16,
    parameter int DEB_CYC       = 1000000,
    parameter int RETURN_FRAMES = 5000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_content,
    input  logic              btn_system,
    output logic [SCAN_W-1:0] scan_idx,
    output logic              content,
    output logic              time_system,
    output logic              blank,
    output logic              frame_tick
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FC_W  = $clog2(RETURN_FRAMES + 1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             slot_end_s;
    logic             frame_end_s;
    logic             press_c_s;
    logic             press_s_s;
    logic             pend_c_r;
    logic             pend_s_r;
    logic [FC_W-1:0]  frame_cnt_r;
    view_state_t      state_r;

    btn_onepulse #(.DEB_CYC(DEB_CYC)) u_btn_content (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_content),
        .press (press_c_s)
    );

    btn_onepulse #(.DEB_CYC(DEB_CYC)) u_btn_system (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_system),
        .press (press_s_s)
    );

    // Next prescaler value and slot / frame end detection.
    always_comb begin
        slot_end_s  = (cnt_r == CNT_W'(SCAN_DIV - 1));
        frame_end_s = slot_end_s && (scan_idx == SCAN_W'(NUM_DIGITS - 1));
        if (slot_end_s) begin
            cnt_next_s = '0;
        end else begin
            cnt_next_s = cnt_r + CNT_W'(1);
        end
    end

    // Prescaler, scan index, blanking and frame tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r      <= '0;
            scan_idx   <= '0;
            blank      <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            cnt_r <= cnt_next_s;
            // Blank is computed from the next count so it stays aligned with cnt_r.
            blank <= (cnt_next_s < CNT_W'(BLANK_CYC));
            if (slot_end_s) begin
                scan_idx <= scan_idx + SCAN_W'(1);
            end
            frame_tick <= frame_end_s;
        end
    end

    // Pending requests: a press toggles its flag; at a boundary the old flag is
    // consumed and a coincident press becomes the request for the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_c_r <= 1'b0;
            pend_s_r <= 1'b0;
        end else if (frame_tick) begin
            pend_c_r <= press_c_s;
            pend_s_r <= press_s_s;
        end else begin
            pend_c_r <= pend_c_r ^ press_c_s;
            pend_s_r <= pend_s_r ^ press_s_s;
        end
    end

    // View FSM, seconds-view frame counter and 12/24 h setting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= HM;
            frame_cnt_r <= '0;
            time_system <= 1'b1;
        end else if (frame_tick) begin
            case (state_r)
                HM: begin
                    if (pend_c_r) begin
                        state_r     <= SEC;
                        frame_cnt_r <= '0;
                    end
                end
                SEC: begin
                    // A manual request and the timeout together still mean one return.
                    if (pend_c_r || (frame_cnt_r == FC_W'(RETURN_FRAMES - 1))) begin
                        state_r     <= HM;
                        frame_cnt_r <= '0;
                    end else begin
                        frame_cnt_r <= frame_cnt_r + FC_W'(1);
                    end
                end
                default: begin
                    state_r     <= HM;
                    frame_cnt_r <= '0;
                end
            endcase
            if (pend_s_r) begin
                time_system <= ~time_system;
            end
        end
    end

    assign content = (state_r == SEC);

endmodule

// File: doc/display_scan_scheduler.md
# display_scan_scheduler

Sequences the 4-digit seven-segment display multiplexer. It generates the digit-scan index that selects which digit the display controller drives, and inserts anti-ghosting blanking at every digit change. It also owns the two user-visible view settings: content (HH:MM vs. seconds) and the 12/24-hour time system. Both settings are taken from debounced push-buttons and applied only on frame boundaries. It sits between the board buttons and the display controller; its `scan_idx`, `content` and `time_system` outputs feed that controller's select inputs directly.

## Interface
- `SCAN_DIV`, default 100000: clock cycles per digit slot (1 kHz digit rate at 100 MHz).
- `BLANK_CYC`, default 16: cycles at the start of each slot during which `blank` is high; must be less than `SCAN_DIV`.
- `DEB_CYC`, default 1000000: cycles a synchronized button level must be stable before it is accepted.
- `RETURN_FRAMES`, default 5000: frames spent in the seconds view before auto-return to HH:MM (20 s at defaults).

Ports (clock and reset first):
- `clk` input 1: system clock. One clock domain only.
- `rst_n` input 1: reset, asynchronous, active-low.
- `btn_content` input 1: raw, asynchronous content button.
- `btn_system` input 1: raw, asynchronous 12/24 h button.
- `scan_idx` output 2: current digit slot, 0 = rightmost digit.
- `content` output 1: 0 = HH:MM view, 1 = seconds view.
- `time_system` output 1: 0 = 12 h, 1 = 24 h.
- `blank` output 1: high means all digit anodes must be off.
- `frame_tick` output 1: one-cycle pulse when `scan_idx` wraps from 3 to 0.

## Operation
- Prescaler `cnt` counts 0..SCAN_DIV-1 and wraps.
  - At `cnt==SCAN_DIV-1`, `scan_idx` increments modulo 4.
  - On the 3→0 wrap, `frame_tick` is high for that one following cycle.
- `blank` is registered and equals 1 while `cnt < BLANK_CYC`, so it covers the first BLANK_CYC cycles of every slot.
- Each button passes through a `btn_onepulse` instance:
  - 2-flop synchronizer, then a stability counter.
  - The accepted level updates after DEB_CYC consecutive cycles differing from the current accepted level. Any bounce clears the counter.
  - A 1-cycle `press` pulse is emitted on each accepted 0→1 transition. Releases produce no pulse.
- Pending flags `pend_c` and `pend_s`:
  - A press toggles its flag, so a second press before the next frame boundary cancels the request.
  - Both flags may be pending at the same time.
- The FSM has two states, `HM` (content=0) and `SEC` (content=1). State changes and `time_system` changes occur only on `frame_tick` cycles.
  - `HM` → `SEC` when `pend_c` is set. This clears `pend_c` and resets `frame_cnt` to 0.
  - `SEC` → `HM` when `pend_c` is set or `frame_cnt==RETURN_FRAMES-1`. Both together cause a single transition to `HM`, and `pend_c` is cleared.
  - In `SEC`, `frame_cnt` increments on each `frame_tick`. It holds in `HM`.
  - If `pend_s` is set, `time_system` toggles and `pend_s` clears. This is independent of and concurrent with the content transition.
- A press pulse arriving in the same cycle as a boundary is registered as pending for the next boundary. It is not applied now.
- Reset values: `cnt`=0, `scan_idx`=0, `blank`=1, `frame_tick`=0, `content`=0 (`HM`), `time_system`=1 (24 h), `frame_cnt`=0, pending flags 0, debouncer accepted levels 0.
- Asserting `rst_n` mid-operation returns all state immediately to the reset values.

## Timing
- All outputs are registered, with no combinational path from input to output.
- Digit slot length is exactly SCAN_DIV cycles. Frame length is 4·SCAN_DIV cycles.
- Button-to-`press` latency is DEB_CYC+2 edges after the first edge that samples the new level. This is 2 synchronizer edges plus the debounce edges and the pulse register.
- Press-to-effect latency: `content` and `time_system` change in the cycle after the next `frame_tick` following `press`, i.e. within 4·SCAN_DIV+1 cycles.
- `blank` rises in the same cycle that `scan_idx` changes. `content` and `time_system` change only while `scan_idx`=0 and `blank`=1.

## Structure
- Shared package `display_pkg`: state encoding (`HM`=1'b0, `SEC`=1'b1), the `scan_idx` width constant (2), and the digit count (4).
- Sub-module `btn_onepulse`, with parameter `DEB_CYC` and ports `clk`, `rst_n`, `btn`, `press`. It is instantiated twice.
- The prescaler, FSM, frame counter and pending flags live in the top level.

## Test plan
Test parameters: SCAN_DIV=8, BLANK_CYC=2, DEB_CYC=3, RETURN_FRAMES=4.
- Reset release, free run → `scan_idx` follows 0,1,2,3,0 with 8 cycles per value; `blank` is high for cycles 0–1 of each slot; `frame_tick` pulses every 32 cycles; `content`=0, `time_system`=1.
- Clean `btn_content` press (held 10 cycles) → `press` DEB_CYC+2 edges later; `content`=1 starting the cycle after the next `frame_tick`.
- `btn_content` bounce (1-cycle glitches shorter than DEB_CYC) → no `press`, `content` unchanged.
- Two content presses within one frame → `pend_c` cancelled, `content` stays 0 at the boundary.
- In `SEC` with no press → return to `content`=0 on the 4th `frame_tick` after entry. With a press pending at that same boundary → a single transition to `HM`, and `pend_c` is 0 afterwards.
- Both buttons pressed in one frame, and `rst_n` pulsed low mid-slot → both settings change on the same boundary; reset returns `scan_idx`=0, `blank`=1, `content`=0, `time_system`=1 asynchronously.
